// File: rtl/vga23_pkg.sv
// Shared definitions for the 2-bit-per-channel serialized VGA link (tx and rx sides).
// Each 3-bit colour code maps to one 6-bit H pattern and one 6-bit L pattern, MSB first.
package vga23_pkg;

  localparam int PIXEL_BITS = 6;

  typedef logic [2:0] code_t;

  typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

  localparam logic [5:0] pattern_h [0:7] = '{
    6'b000000, 6'b000000, 6'b000000, 6'b101010,
    6'b101010, 6'b101010, 6'b111111, 6'b111111
  };

  localparam logic [5:0] pattern_l [0:7] = '{
    6'b000000, 6'b010010, 6'b111111, 6'b000000,
    6'b010010, 6'b111111, 6'b101101, 6'b111111
  };

  // Returns {legal, code}; only an exact match on both patterns is legal.
  function automatic logic [3:0] decode_pair(input logic [5:0] h, input logic [5:0] l);
    decode_pair = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (h == pattern_h[i] && l == pattern_l[i]) decode_pair = {1'b1, 3'(i)};
    end
  endfunction

endpackage

// File: rtl/vga23_chan_dec.sv
// One colour channel: deserializes the H/L lines and decodes them to a 3-bit code.
// Latency: code updates on the edge where i_dec is high; illegal patterns keep the last code; no backpressure.
module vga23_chan_dec
  import vga23_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_line,
  input  logic       i_shift,
  input  logic       i_dec,
  output code_t      o_code,
  output logic       o_illegal
);

  logic [5:0] r_sh_h;
  logic [5:0] r_sh_l;
  code_t      r_code;
  logic [3:0] w_dec;

  assign w_dec     = decode_pair(r_sh_h, r_sh_l);
  assign o_code    = r_code;
  assign o_illegal = ~w_dec[3];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh_h <= '0;
      r_sh_l <= '0;
      r_code <= '0;
    end else begin
      if (i_shift) begin
        if (LSB_FIRST) begin
          r_sh_h <= {i_line[1], r_sh_h[5:1]};
          r_sh_l <= {i_line[0], r_sh_l[5:1]};
        end else begin
          r_sh_h <= {r_sh_h[4:0], i_line[1]};
          r_sh_l <= {r_sh_l[4:0], i_line[0]};
        end
      end
      if (i_dec && w_dec[3]) r_code <= w_dec[2:0];
    end
  end

endmodule

// File: rtl/vga23_capture.sv
// Receiver for the serialized 2-bit VGA link: HS-aligned pixel framing and colour decode.
// Latency: oVALID one serial clock after the last bit of a pixel is sampled; no backpressure.
module vga23_capture
  import vga23_pkg::*;
#(
  parameter logic HS_ACTIVE    = 1'b0,
  parameter int   PHASE_OFFSET = 0,
  parameter bit   LSB_FIRST    = 1'b0,
  parameter int   ERRCNT_W     = 16
) (
  input  logic                CLKSerial,
  input  logic                nRESET,
  input  logic                iHS,
  input  logic                iVS,
  input  logic [1:0]          iRED,
  input  logic [1:0]          iGREEN,
  input  logic [1:0]          iBLUE,
  output logic [2:0]          oRED,
  output logic [2:0]          oGREEN,
  output logic [2:0]          oBLUE,
  output logic                oHS,
  output logic                oVS,
  output logic                oVALID,
  output logic                oPIXERR,
  output logic                oLOCKED,
  output logic [ERRCNT_W-1:0] oERRCNT
);

  localparam int LOAD_PHASE = (PIXEL_BITS - PHASE_OFFSET) % PIXEL_BITS;
  // Counter value seen on an HS edge that is already in step with the framing.
  localparam int EDGE_PHASE = (LOAD_PHASE + PIXEL_BITS - 1) % PIXEL_BITS;

  state_t              r_state;
  logic [2:0]          r_phase;
  logic                r_hs_prev;
  logic                r_hs_hold;
  logic                r_vs_hold;
  logic                r_dec_stb;
  logic                r_valid;
  logic                r_pixerr;
  logic                r_hs;
  logic                r_vs;
  logic [ERRCNT_W-1:0] r_errcnt;

  logic                w_hs_edge;
  logic                w_realign;
  logic                w_shift;
  logic [2:0]          w_ill;

  assign w_hs_edge = (r_hs_prev != HS_ACTIVE) && (iHS == HS_ACTIVE);
  assign w_realign = w_hs_edge && ((r_state == SEEK) || (r_phase != 3'(EDGE_PHASE)));
  assign w_shift   = (r_state == RUN) && !w_realign;

  vga23_chan_dec #(.LSB_FIRST(LSB_FIRST)) u_red (
    .i_clk(CLKSerial), .i_rst_n(nRESET), .i_line(iRED), .i_shift(w_shift),
    .i_dec(r_dec_stb), .o_code(oRED), .o_illegal(w_ill[2])
  );

  vga23_chan_dec #(.LSB_FIRST(LSB_FIRST)) u_green (
    .i_clk(CLKSerial), .i_rst_n(nRESET), .i_line(iGREEN), .i_shift(w_shift),
    .i_dec(r_dec_stb), .o_code(oGREEN), .o_illegal(w_ill[1])
  );

  vga23_chan_dec #(.LSB_FIRST(LSB_FIRST)) u_blue (
    .i_clk(CLKSerial), .i_rst_n(nRESET), .i_line(iBLUE), .i_shift(w_shift),
    .i_dec(r_dec_stb), .o_code(oBLUE), .o_illegal(w_ill[0])
  );

  always_ff @(posedge CLKSerial) begin
    if (!nRESET) begin
      r_state   <= SEEK;
      r_phase   <= '0;
      r_hs_prev <= HS_ACTIVE;
      r_hs_hold <= 1'b0;
      r_vs_hold <= 1'b0;
      r_dec_stb <= 1'b0;
      r_valid   <= 1'b0;
      r_pixerr  <= 1'b0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_errcnt  <= '0;
    end else begin
      r_hs_prev <= iHS;
      r_dec_stb <= 1'b0;
      r_valid   <= r_dec_stb;
      r_pixerr  <= r_dec_stb && (|w_ill);
      if (r_dec_stb) begin
        r_hs <= r_hs_hold;
        r_vs <= r_vs_hold;
        if ((|w_ill) && (r_errcnt != '1)) r_errcnt <= r_errcnt + 1'b1;
      end
      // A realign drops the pixel in flight, including one whose last bit lands now.
      if (w_realign) begin
        r_state <= RUN;
        r_phase <= 3'(LOAD_PHASE);
      end else if (r_state == RUN) begin
        if (r_phase == 3'd0) begin
          r_hs_hold <= iHS;
          r_vs_hold <= iVS;
        end
        r_dec_stb <= (r_phase == 3'(PIXEL_BITS - 1));
        r_phase   <= (r_phase == 3'(PIXEL_BITS - 1)) ? 3'd0 : r_phase + 3'd1;
      end
    end
  end

  assign oHS     = r_hs;
  assign oVS     = r_vs;
  assign oVALID  = r_valid;
  assign oPIXERR = r_pixerr;
  assign oLOCKED = (r_state == RUN);
  assign oERRCNT = r_errcnt;

endmodule

// File: tb/tb_vga23_capture.sv
// Directed bench for vga23_capture with HS_ACTIVE=0, PHASE_OFFSET=0, MSB-first, 3-bit error counter.
module tb_vga23_capture;

  logic       clk;
  logic       nrst;
  logic       hs, vs;
  logic [1:0] red, green, blue;
  logic [2:0] o_red, o_green, o_blue;
  logic       o_hs, o_vs, o_valid, o_pixerr, o_locked;
  logic [2:0] o_errcnt;

  int n_checks = 0;
  int n_errors = 0;
  int vseen, vpos, idle_v;
  logic [2:0] cap_r, cap_g, cap_b;
  logic       cap_err, cap_hs, cap_vs;

  logic [5:0] tb_pat_h [0:7] = '{6'b000000, 6'b000000, 6'b000000, 6'b101010,
                                 6'b101010, 6'b101010, 6'b111111, 6'b111111};
  logic [5:0] tb_pat_l [0:7] = '{6'b000000, 6'b010010, 6'b111111, 6'b000000,
                                 6'b010010, 6'b111111, 6'b101101, 6'b111111};

  vga23_capture #(.HS_ACTIVE(1'b0), .PHASE_OFFSET(0), .LSB_FIRST(1'b0), .ERRCNT_W(3)) dut (
    .CLKSerial(clk), .nRESET(nrst), .iHS(hs), .iVS(vs),
    .iRED(red), .iGREEN(green), .iBLUE(blue),
    .oRED(o_red), .oGREEN(o_green), .oBLUE(o_blue),
    .oHS(o_hs), .oVS(o_vs), .oVALID(o_valid), .oPIXERR(o_pixerr),
    .oLOCKED(o_locked), .oERRCNT(o_errcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 6-bit pixel slot MSB first and records any oVALID seen while doing so.
  task automatic send_raw(input logic [5:0] rh, input logic [5:0] rl, input logic [5:0] gh,
                          input logic [5:0] gl, input logic [5:0] bh, input logic [5:0] bl,
                          input logic h, input logic v);
    vseen = 0;
    vpos  = 0;
    for (int k = 5; k >= 0; k--) begin
      red = {rh[k], rl[k]};
      green = {gh[k], gl[k]};
      blue = {bh[k], bl[k]};
      hs = h;
      vs = v;
      tick();
      if (o_valid) begin
        vseen++;
        vpos = 6 - k;
        cap_r = o_red; cap_g = o_green; cap_b = o_blue;
        cap_err = o_pixerr; cap_hs = o_hs; cap_vs = o_vs;
      end
    end
  endtask

  task automatic send_pixel(input int r, input int g, input int b, input logic h, input logic v);
    send_raw(tb_pat_h[r], tb_pat_l[r], tb_pat_h[g], tb_pat_l[g], tb_pat_h[b], tb_pat_l[b], h, v);
  endtask

  task automatic chk_pix(input string tag, input int r, input int g, input int b, input logic err);
    chk({tag, "_nvalid"}, vseen, 1);
    chk({tag, "_vpos"}, vpos, 1);
    chk({tag, "_red"}, cap_r, r);
    chk({tag, "_green"}, cap_g, g);
    chk({tag, "_blue"}, cap_b, b);
    chk({tag, "_pixerr"}, cap_err, err);
  endtask

  initial begin
    nrst = 1'b0; hs = 1'b1; vs = 1'b0; red = 2'b00; green = 2'b00; blue = 2'b00;
    tick(); tick();
    chk("rst_locked", o_locked, 0);
    chk("rst_outs", {o_red, o_green, o_blue, o_hs, o_vs, o_valid, o_pixerr}, 0);
    chk("rst_errcnt", o_errcnt, 0);
    nrst = 1'b1;

    // No HS edge: lines toggling but nothing must be decoded.
    idle_v = 0;
    for (int i = 0; i < 100; i++) begin
      red = 2'(i); green = 2'b11; blue = 2'(i + 1);
      tick();
      if (o_valid) idle_v++;
    end
    chk("idle_valid", idle_v, 0);
    chk("idle_locked", o_locked, 0);
    chk("idle_outs", {o_red, o_green, o_blue, o_hs, o_vs, o_pixerr}, 0);

    // HS active edge, then the first pixel.
    red = 2'b00; green = 2'b00; blue = 2'b00; hs = 1'b0; vs = 1'b1;
    tick();
    chk("edge_locked", o_locked, 1);
    chk("edge_valid", o_valid, 0);
    send_pixel(6, 4, 0, 1'b0, 1'b1);
    chk("p1_no_early_valid", vseen, 0);

    // Sweep 0..7; each call observes the previous pixel at its first bit.
    send_pixel(0, 0, 0, 1'b1, 1'b0);
    chk_pix("first", 6, 4, 0, 1'b0);
    chk("first_hs", cap_hs, 0);
    chk("first_vs", cap_vs, 1);
    for (int c = 1; c < 8; c++) begin
      send_pixel(c, c, c, 1'b1, 1'b0);
      chk_pix("sweep", c - 1, c - 1, c - 1, 1'b0);
    end
    send_pixel(5, 1, 2, 1'b1, 1'b0);
    chk_pix("sweep7", 7, 7, 7, 1'b0);
    chk("sweep_hs", cap_hs, 1);
    chk("sweep_vs", cap_vs, 0);

    // Illegal red pattern following red=5.
    send_raw(6'b110000, 6'b000000, tb_pat_h[3], tb_pat_l[3], tb_pat_h[6], tb_pat_l[6], 1'b1, 1'b0);
    chk_pix("pre_err", 5, 1, 2, 1'b0);
    chk("pre_err_cnt", o_errcnt, 0);
    send_pixel(2, 0, 0, 1'b1, 1'b0);
    chk_pix("err", 5, 3, 6, 1'b1);
    chk("err_cnt", o_errcnt, 1);
    chk("err_pulse_len", o_pixerr, 0);

    // Drive the counter into saturation with all-channel illegal pixels.
    for (int i = 0; i < 7; i++) send_raw(6'b000001, 6'b0, 6'b000001, 6'b0, 6'b000001, 6'b0, 1'b1, 1'b0);
    chk_pix("held", 2, 0, 0, 1'b1);
    chk("sat_reach", o_errcnt, 7);
    send_pixel(1, 1, 1, 1'b1, 1'b0);
    chk_pix("sat_held", 2, 0, 0, 1'b1);
    chk("sat_stay", o_errcnt, 7);

    // HS edge in the middle of a pixel (at phase 3).
    idle_v = 0;
    for (int i = 0; i < 3; i++) begin
      red = {tb_pat_h[3][5 - i], tb_pat_l[3][5 - i]}; green = 2'b00; blue = 2'b00; hs = 1'b1;
      tick();
      if (o_valid) idle_v++;
    end
    chk("pre_realign_valid", idle_v, 1);
    hs = 1'b0;
    tick();
    chk("realign_edge_valid", o_valid, 0);
    send_pixel(1, 5, 7, 1'b0, 1'b0);
    chk("realign_no_partial", vseen, 0);
    chk("realign_locked", o_locked, 1);
    send_pixel(4, 2, 6, 1'b0, 1'b0);
    chk_pix("realign", 1, 5, 7, 1'b0);
    chk("realign_cnt", o_errcnt, 7);

    // One-cycle reset in the middle of a pixel.
    for (int i = 0; i < 3; i++) begin
      red = 2'b11; green = 2'b10; blue = 2'b01;
      tick();
    end
    nrst = 1'b0; hs = 1'b1;
    tick();
    nrst = 1'b1;
    chk("mrst_outs", {o_red, o_green, o_blue, o_hs, o_vs, o_valid, o_pixerr}, 0);
    chk("mrst_cnt", o_errcnt, 0);
    chk("mrst_locked", o_locked, 0);
    send_pixel(3, 3, 3, 1'b1, 1'b0);
    chk("mrst_valid_a", vseen, 0);
    send_pixel(5, 5, 5, 1'b1, 1'b0);
    chk("mrst_valid_b", vseen, 0);
    chk("mrst_still_unlocked", o_locked, 0);
    hs = 1'b0;
    tick();
    chk("relock", o_locked, 1);
    send_pixel(7, 3, 1, 1'b0, 1'b1);
    send_pixel(0, 0, 0, 1'b1, 1'b0);
    chk_pix("relock_pix", 7, 3, 1, 1'b0);
    chk("relock_hs", cap_hs, 0);
    chk("relock_vs", cap_vs, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
